// File: rtl/snes_addr_map_if.sv
// snes_addr_map_if: bus bundle between the SNES/MCU side and snes_addr_map.
//   master : drives SNES_ADDR and the cfg_* write/commit strobes, observes
//            cfg_busy and the map_* / trig_pulse results.
//   slave  : the mapper itself (inverse directions).
// NUM_TRIG sets the trig_pulse width and must match the mapper's NUM_TRIG.
interface snes_addr_map_if #(
    parameter int unsigned NUM_TRIG = 3
);
    logic [23:0]         SNES_ADDR;
    logic                cfg_we;
    logic [5:0]          cfg_addr;
    logic [31:0]         cfg_data;
    logic                cfg_commit;
    logic                cfg_busy;
    logic [23:0]         map_addr;
    logic [2:0]          map_sel;
    logic                map_hit;
    logic                map_valid;
    logic [NUM_TRIG-1:0] trig_pulse;

    modport master (
        output SNES_ADDR, cfg_we, cfg_addr, cfg_data, cfg_commit,
        input  cfg_busy, map_addr, map_sel, map_hit, map_valid, trig_pulse
    );

    modport slave (
        input  SNES_ADDR, cfg_we, cfg_addr, cfg_data, cfg_commit,
        output cfg_busy, map_addr, map_sel, map_hit, map_valid, trig_pulse
    );
endinterface

// File: rtl/snes_addr_map.sv
// snes_addr_map: programmable SNES address mapper.
//   CLK, RST_N : single clock, synchronous active-low reset.
//   bus        : snes_addr_map_if.slave
//     SNES_ADDR (async in), cfg_we/cfg_addr/cfg_data shadow-table writes,
//     cfg_commit/cfg_busy atomic shadow->active copy at an address boundary,
//     map_addr/map_sel/map_hit translated address of the lowest matching
//     window, map_valid address stable, trig_pulse delayed trigger pulses.
// Register map: window w word k at index 3w+k, trigger t at 3*NUM_WIN+t.
module snes_addr_map #(
    parameter int unsigned NUM_WIN    = 4,
    parameter int unsigned NUM_TRIG   = 3,
    parameter int unsigned TRIG_DELAY = 3,
    parameter int unsigned STABLE     = 2
) (
    input logic             CLK,
    input logic             RST_N,
    snes_addr_map_if.slave  bus
);

    typedef struct packed {
        logic        en;
        logic [7:0]  bval;
        logic [7:0]  bmask;
        logic [1:0]  a15m;
        logic [23:0] amask;
        logic [23:0] base;
    } win_t;

    typedef struct packed {
        logic        en;
        logic [23:0] match;
    } trig_t;

    typedef enum logic {C_IDLE, C_PEND} commit_t;

    win_t    win_sh  [NUM_WIN];
    win_t    win_act [NUM_WIN];
    trig_t   trg_sh  [NUM_TRIG];
    trig_t   trg_act [NUM_TRIG];

    commit_t cst_q, cst_d;
    logic    load;

    logic [23:0] a1, a2;
    logic        change;
    logic [3:0]  cnt;

    logic        hit_d;
    logic [2:0]  sel_d;
    logic [23:0] addr_d;

    logic [NUM_TRIG-1:0] trig_hit, trig_prev, trig_rise;
    logic [NUM_TRIG-1:0] trig_sr [TRIG_DELAY];

    function automatic logic a15_ok(input logic [1:0] mode, input logic a15);
        case (mode)
            2'd1:    return a15;
            2'd2:    return !a15;
            default: return 1'b1;
        endcase
    endfunction

    assign change       = (a1 != a2);
    assign bus.cfg_busy = (cst_q == C_PEND);

    // Shadow table: plain register file, written by the MCU at any time.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int unsigned w = 0; w < NUM_WIN; w++)  win_sh[w] <= '0;
            for (int unsigned t = 0; t < NUM_TRIG; t++) trg_sh[t] <= '0;
        end else if (bus.cfg_we) begin
            for (int unsigned w = 0; w < NUM_WIN; w++) begin
                if (32'(bus.cfg_addr) == 3*w) begin
                    win_sh[w].en    <= bus.cfg_data[31];
                    win_sh[w].bval  <= bus.cfg_data[23:16];
                    win_sh[w].bmask <= bus.cfg_data[15:8];
                    win_sh[w].a15m  <= bus.cfg_data[1:0];
                end
                if (32'(bus.cfg_addr) == 3*w + 1) win_sh[w].amask <= bus.cfg_data[23:0];
                if (32'(bus.cfg_addr) == 3*w + 2) win_sh[w].base  <= bus.cfg_data[23:0];
            end
            for (int unsigned t = 0; t < NUM_TRIG; t++) begin
                if (32'(bus.cfg_addr) == 3*NUM_WIN + t) begin
                    trg_sh[t].en    <= bus.cfg_data[31];
                    trg_sh[t].match <= bus.cfg_data[23:0];
                end
            end
        end
    end

    // Active table only changes on a commit load.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int unsigned w = 0; w < NUM_WIN; w++)  win_act[w] <= '0;
            for (int unsigned t = 0; t < NUM_TRIG; t++) trg_act[t] <= '0;
        end else if (load) begin
            for (int unsigned w = 0; w < NUM_WIN; w++)  win_act[w] <= win_sh[w];
            for (int unsigned t = 0; t < NUM_TRIG; t++) trg_act[t] <= trg_sh[t];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) cst_q <= C_IDLE;
        else        cst_q <= cst_d;
    end

    // The load waits for an address boundary (a2 about to change) or for an
    // unsettled address, so a remap never lands mid-access. Commits seen
    // while pending are absorbed.
    always_comb begin
        cst_d = cst_q;
        load  = 1'b0;
        case (cst_q)
            C_IDLE: if (bus.cfg_commit) cst_d = C_PEND;
            C_PEND: if (change || !bus.map_valid) begin
                load  = 1'b1;
                cst_d = C_IDLE;
            end
            default: cst_d = C_IDLE;
        endcase
    end

    // Lowest-indexed matching window wins.
    always_comb begin
        hit_d  = 1'b0;
        sel_d  = '0;
        addr_d = '0;
        for (int unsigned w = 0; w < NUM_WIN; w++) begin
            if (!hit_d && win_act[w].en &&
                ((a2[23:16] & win_act[w].bmask) == (win_act[w].bval & win_act[w].bmask)) &&
                a15_ok(win_act[w].a15m, a2[15])) begin
                hit_d  = 1'b1;
                sel_d  = 3'(w);
                addr_d = win_act[w].base + (a2 & win_act[w].amask);
            end
        end
    end

    always_comb begin
        for (int unsigned t = 0; t < NUM_TRIG; t++)
            trig_hit[t] = trg_act[t].en && (a2 == trg_act[t].match);
    end

    assign trig_rise = trig_hit & ~trig_prev;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            a1             <= '0;
            a2             <= '0;
            cnt            <= '0;
            bus.map_valid  <= 1'b0;
            bus.map_hit    <= 1'b0;
            bus.map_sel    <= '0;
            bus.map_addr   <= '0;
            trig_prev      <= '0;
            for (int unsigned i = 0; i < TRIG_DELAY; i++) trig_sr[i] <= '0;
            bus.trig_pulse <= '0;
        end else begin
            a1 <= bus.SNES_ADDR;
            a2 <= a1;
            if (change)                  cnt <= '0;
            else if (cnt != 4'(STABLE))  cnt <= cnt + 4'd1;
            bus.map_valid <= (cnt == 4'(STABLE)) && !change;
            bus.map_hit   <= hit_d;
            bus.map_sel   <= sel_d;
            bus.map_addr  <= addr_d;
            trig_prev     <= trig_hit;
            trig_sr[0]    <= trig_rise;
            for (int unsigned i = 1; i < TRIG_DELAY; i++) trig_sr[i] <= trig_sr[i-1];
            bus.trig_pulse <= trig_sr[TRIG_DELAY-1];
        end
    end

endmodule
